// File: rtl/play_ctrl.sv
// play_ctrl -- transport controller for a record/playback audio path backed by
// an asynchronous SRAM. Every piece of logic runs on the rising edge of bclk.
//
// Ports
//   bclk        audio bit clock
//   rst         synchronous reset, active-high
//   key_play    one-cycle command pulse (debounced upstream)
//   key_pause   one-cycle command pulse
//   key_stop    one-cycle command pulse
//   key_rec     one-cycle command pulse
//   fast[3:0]   playback address stride; 0 behaves as 1
//   slow[3:0]   frames held on each address; 0 behaves as 1
//   daclrc      DAC left/right clock, synchronous to bclk
//   adc_valid   one-cycle pulse: the recorder has a word on the SRAM data bus
//   sram_addr   SRAM word address (registered, always driven)
//   sram_we_n   SRAM write strobe, active-low
//   sram_oe_n   SRAM output enable, active-low
//   play        enables the DAC serializer (high only in PLAY)
//   rec         enables the ADC deserializer (high only in RECORD)
//   state[1:0]  IDLE=0, PLAY=1, PAUSE=2, RECORD=3
//   done        one-cycle pulse at the end of a recording or a playback
//
// Build option
//   PLAY_CTRL_LOOP_EN  when defined, playback that runs past the recorded end
//                      wraps to address 0 and stays in PLAY (done still
//                      pulses). When undefined, playback returns to IDLE.
//
// Command handshake: the key_* inputs are single-cycle strobes with no
// acknowledge. A strobe is sampled on one bclk edge and its effect appears on
// the registered outputs right after that edge. Simultaneous strobes resolve
// as key_stop > key_rec > key_play > key_pause.

module play_ctrl #(
  parameter logic [17:0] ADDR_MAX = 18'h3FFFF
) (
  input  logic        bclk,
  input  logic        rst,
  input  logic        key_play,
  input  logic        key_pause,
  input  logic        key_stop,
  input  logic        key_rec,
  input  logic [3:0]  fast,
  input  logic [3:0]  slow,
  input  logic        daclrc,
  input  logic        adc_valid,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        play,
  output logic        rec,
  output logic [1:0]  state,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSE  = 2'd2,
    S_RECORD = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_nx;
  logic [17:0] addr_nx;
  logic [17:0] end_addr;
  logic [17:0] end_nx;
  logic [3:0]  frame_cnt;
  logic [3:0]  cnt_nx;
  logic        we_n_nx;
  logic        done_nx;
  logic        daclrc_q;

  logic [3:0]  fast_eff;
  logic [3:0]  slow_eff;
  logic [18:0] adv_addr;
  logic        past_end;
  logic        lrc_rise;

  assign fast_eff = (fast == 4'd0) ? 4'd1 : fast;
  assign slow_eff = (slow == 4'd0) ? 4'd1 : slow;

  // One bit wider than the address so a stride near the top of memory cannot
  // wrap around and look like a legal in-range address.
  assign adv_addr = {1'b0, sram_addr} + {15'd0, fast_eff};
  assign past_end = adv_addr > {1'b0, end_addr};
  assign lrc_rise = daclrc & ~daclrc_q;

  assign state = state_q;

  always_comb begin
    state_nx = state_q;
    addr_nx  = sram_addr;
    end_nx   = end_addr;
    cnt_nx   = frame_cnt;
    we_n_nx  = 1'b1;
    done_nx  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_rec) begin
          // A new take starts with an empty recording.
          state_nx = S_RECORD;
          addr_nx  = 18'd0;
          end_nx   = 18'd0;
        end else if (key_play && (end_addr != 18'd0)) begin
          state_nx = S_PLAY;
          addr_nx  = 18'd0;
        end
      end

      S_PLAY, S_PAUSE: begin
        if (key_stop) begin
          state_nx = S_IDLE;
          addr_nx  = 18'd0;
        end else if (key_rec) begin
          state_nx = S_RECORD;
          addr_nx  = 18'd0;
          end_nx   = 18'd0;
        end else if (key_play && (state_q == S_PAUSE)) begin
          state_nx = S_PLAY;
        end else if (key_pause && (state_q == S_PLAY)) begin
          state_nx = S_PAUSE;
        end else if ((state_q == S_PLAY) && lrc_rise) begin
          // ">=" rather than "==" so a slow value lowered mid-playback
          // cannot strand the counter above its new terminal count.
          if (frame_cnt >= (slow_eff - 4'd1)) begin
            cnt_nx = 4'd0;
            if (past_end) begin
              done_nx = 1'b1;
              addr_nx = 18'd0;
`ifdef PLAY_CTRL_LOOP_EN
              state_nx = S_PLAY;
`else
              state_nx = S_IDLE;
`endif
            end else begin
              addr_nx = adv_addr[17:0];
            end
          end else begin
            cnt_nx = frame_cnt + 4'd1;
          end
        end
      end

      S_RECORD: begin
        // sram_we_n low means this cycle is the write strobe: the word at
        // sram_addr is committed whatever else happens this cycle.
        if (!sram_we_n) begin
          end_nx = sram_addr;
        end
        if (key_stop) begin
          state_nx = S_IDLE;
          addr_nx  = 18'd0;
        end else if (!sram_we_n) begin
          if (sram_addr == ADDR_MAX) begin
            done_nx  = 1'b1;
            state_nx = S_IDLE;
            addr_nx  = 18'd0;
          end else begin
            addr_nx = sram_addr + 18'd1;
          end
        end else if (adc_valid) begin
          // A pulse arriving during the strobe cycle falls through to the
          // branch above and is dropped.
          we_n_nx = 1'b0;
        end
      end

      default: begin
        state_nx = S_IDLE;
        addr_nx  = 18'd0;
      end
    endcase

    // Any state entry restarts frame counting.
    if (state_nx != state_q) begin
      cnt_nx = 4'd0;
    end
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sram_addr <= 18'd0;
      end_addr  <= 18'd0;
      frame_cnt <= 4'd0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      play      <= 1'b0;
      rec       <= 1'b0;
      done      <= 1'b0;
      daclrc_q  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      sram_addr <= addr_nx;
      end_addr  <= end_nx;
      frame_cnt <= cnt_nx;
      sram_we_n <= we_n_nx;
      sram_oe_n <= !((state_nx == S_PLAY) || (state_nx == S_PAUSE));
      play      <= (state_nx == S_PLAY);
      rec       <= (state_nx == S_RECORD);
      done      <= done_nx;
      daclrc_q  <= daclrc;
    end
  end

endmodule

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl. Stimulus tasks push every output change they
// expect onto exp_q; a monitor on the falling edge pops one entry each time
// the observed output bundle changes and compares it.

module tb_play_ctrl;

  localparam logic [17:0] AMAX     = 18'd15;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_PLAY   = 2'd1;
  localparam logic [1:0]  S_PAUSE  = 2'd2;
  localparam logic [1:0]  S_RECORD = 2'd3;

  logic        bclk = 1'b0;
  logic        rst = 1'b1;
  logic        key_play = 1'b0;
  logic        key_pause = 1'b0;
  logic        key_stop = 1'b0;
  logic        key_rec = 1'b0;
  logic [3:0]  fast = 4'd1;
  logic [3:0]  slow = 4'd1;
  logic        daclrc = 1'b0;
  logic        adc_valid = 1'b0;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        play;
  logic        rec;
  logic [1:0]  state;
  logic        done;

  logic [24:0] exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic        mon_en = 1'b0;
  logic        first = 1'b1;
  logic [24:0] prev_snap = '0;

  // clock / reset
  always #5 bclk = ~bclk;

  play_ctrl #(.ADDR_MAX(AMAX)) dut (
    .bclk      (bclk),
    .rst       (rst),
    .key_play  (key_play),
    .key_pause (key_pause),
    .key_stop  (key_stop),
    .key_rec   (key_rec),
    .fast      (fast),
    .slow      (slow),
    .daclrc    (daclrc),
    .adc_valid (adc_valid),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .play      (play),
    .rec       (rec),
    .state     (state),
    .done      (done)
  );

  // Expected output bundle {done, we_n, oe_n, play, rec, state, addr};
  // oe_n/play/rec follow from the state.
  function automatic logic [24:0] mk(input logic d, input logic w,
                                     input logic [1:0] st, input logic [17:0] a);
    logic oe_n;
    oe_n = !((st == S_PLAY) || (st == S_PAUSE));
    return {d, w, oe_n, (st == S_PLAY), (st == S_RECORD), st, a};
  endfunction

  // scoreboard monitor
  always @(negedge bclk) begin
    logic [24:0] snap;
    logic [24:0] e;
    if (mon_en) begin
      snap = {done, sram_we_n, sram_oe_n, play, rec, state, sram_addr};
      if (first || (snap != prev_snap)) begin
        compared = compared + 1;
        if (exp_q.size() == 0) begin
          mismatched = mismatched + 1;
          $display("FAIL unexpected_change at %0t: got %h, none expected", $time, snap);
        end else begin
          e = exp_q.pop_front();
          if (snap !== e) begin
            mismatched = mismatched + 1;
            $display("FAIL event at %0t: got done=%b we_n=%b oe_n=%b play=%b rec=%b state=%0d addr=%0d, exp done=%b we_n=%b oe_n=%b play=%b rec=%b state=%0d addr=%0d",
                     $time, snap[24], snap[23], snap[22], snap[21], snap[20], snap[19:18], snap[17:0],
                     e[24], e[23], e[22], e[21], e[20], e[19:18], e[17:0]);
          end
        end
        prev_snap = snap;
        first = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic keys(input logic p, input logic pa, input logic s, input logic r);
    key_play = p; key_pause = pa; key_stop = s; key_rec = r;
    tick(1);
    key_play = 0; key_pause = 0; key_stop = 0; key_rec = 0;
  endtask

  task automatic frame();
    daclrc = 1'b1;
    tick(2);
    daclrc = 1'b0;
    tick(2);
  endtask

  // One recorded word at address a; hold2 issues a second adc_valid pulse
  // during the strobe cycle, which must be dropped.
  task automatic write_word(input logic [17:0] a, input logic hold2);
    exp_q.push_back(mk(0, 0, S_RECORD, a));
    if (a == AMAX) begin
      exp_q.push_back(mk(1, 1, S_IDLE, 18'd0));
      exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    end else begin
      exp_q.push_back(mk(0, 1, S_RECORD, a + 18'd1));
    end
    adc_valid = 1'b1;
    tick(hold2 ? 2 : 1);
    adc_valid = 1'b0;
    tick(3);
  endtask

  task automatic record_take(input int nwords);
    exp_q.push_back(mk(0, 1, S_RECORD, 18'd0));
    keys(0, 0, 0, 1);
    tick(2);
    for (int i = 0; i < nwords; i++) write_word(18'(i), 1'b0);
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    keys(0, 0, 1, 0);
    tick(3);
  endtask

  // The frame that runs past end_addr.
  task automatic end_frame();
`ifdef PLAY_CTRL_LOOP_EN
    exp_q.push_back(mk(1, 1, S_PLAY, 18'd0));
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd0));
    frame();
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    keys(0, 0, 1, 0);
    tick(2);
`else
    exp_q.push_back(mk(1, 1, S_IDLE, 18'd0));
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    frame();
`endif
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    tick(3);
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Nothing recorded: play and pause in IDLE are ignored.
    keys(1, 0, 0, 0);
    keys(0, 1, 0, 0);
    tick(3);

    // Five words at 0..4, then stop; end_addr = 4.
    record_take(5);

    // fast=1 slow=1: 0 -> 1,2,3,4 then done.
    fast = 4'd1; slow = 4'd1;
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd0));
    keys(1, 0, 0, 0);
    tick(2);
    for (int a = 1; a <= 4; a++) begin
      exp_q.push_back(mk(0, 1, S_PLAY, 18'(a)));
      frame();
    end
    end_frame();
    tick(3);

    // end_addr = 10; fast=3 slow=2: 0,3,6,9 two frames each, then done.
    record_take(11);
    fast = 4'd3; slow = 4'd2;
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd0));
    keys(1, 0, 0, 0);
    tick(2);
    for (int a = 3; a <= 9; a += 3) begin
      frame();
      exp_q.push_back(mk(0, 1, S_PLAY, 18'(a)));
      frame();
    end
    frame();
    end_frame();
    tick(3);

    // Pause at 6 with the frame counter part-way, resume with it cleared.
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd0));
    keys(1, 0, 0, 0);
    tick(2);
    frame();
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd3));
    frame();
    frame();
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd6));
    frame();
    frame();
    exp_q.push_back(mk(0, 1, S_PAUSE, 18'd6));
    keys(0, 1, 0, 0);
    tick(2);
    for (int i = 0; i < 3; i++) frame();
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd6));
    keys(1, 0, 0, 0);
    tick(2);
    frame();
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd9));
    frame();

    // Stop and play together: stop wins, no done.
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    keys(1, 0, 1, 0);
    tick(3);

    // fast=0 slow=0 behave as 1.
    fast = 4'd0; slow = 4'd0;
    exp_q.push_back(mk(0, 1, S_PLAY, 18'd0));
    keys(1, 0, 0, 0);
    tick(2);
    for (int a = 1; a <= 3; a++) begin
      exp_q.push_back(mk(0, 1, S_PLAY, 18'(a)));
      frame();
    end
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    keys(0, 0, 1, 0);
    tick(3);

    // rec+play together from IDLE -> RECORD; fill memory to ADDR_MAX.
    exp_q.push_back(mk(0, 1, S_RECORD, 18'd0));
    keys(1, 0, 0, 1);
    tick(2);
    write_word(18'd0, 1'b1);
    for (int a = 1; a <= 15; a++) write_word(18'(a), 1'b0);
    tick(3);

    // Reset during a write strobe discards the recording.
    exp_q.push_back(mk(0, 1, S_RECORD, 18'd0));
    keys(0, 0, 0, 1);
    tick(2);
    exp_q.push_back(mk(0, 0, S_RECORD, 18'd0));
    exp_q.push_back(mk(0, 1, S_IDLE, 18'd0));
    adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    keys(1, 0, 0, 0);
    tick(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    if (exp_q.size() != 0) begin
      $display("FAIL missing_events: got %0d still pending, exp 0", exp_q.size());
      compared = compared + exp_q.size();
      mismatched = mismatched + exp_q.size();
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, exp completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/play_ctrl.md
PLAY_CTRL -- requirements
Module: play_ctrl

Interface
REQ-001 Parameter ADDR_MAX, default 18'h3FFFF, last usable SRAM word address.
REQ-002 bclk  input  1  audio bit clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 key_play / key_pause / key_stop / key_rec  input  1 each  one-cycle command pulses (debounced upstream).
REQ-005 fast  input  4  playback address stride; 0 treated as 1.
REQ-006 slow  input  4  frames held per address; 0 treated as 1.
REQ-007 daclrc  input  1  DAC left/right clock, synchronous to bclk.
REQ-008 adc_valid  input  1  one-cycle pulse: recorder has a 16-bit word ready on the SRAM data bus.
REQ-009 sram_addr  output  18  SRAM word address, always driven.
REQ-010 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-011 sram_oe_n  output  1  SRAM output enable, active-low.
REQ-012 play  output  1  enables the DAC serializer; high only in PLAY.
REQ-013 rec  output  1  enables the ADC deserializer; high only in RECORD.
REQ-014 state  output  2  IDLE=0, PLAY=1, PAUSE=2, RECORD=3.
REQ-015 done  output  1  one-cycle pulse on end of recording or playback.

Function
REQ-016 All outputs registered; state changes one cycle after the command pulse.
REQ-017 Simultaneous commands resolve by priority key_stop > key_rec > key_play > key_pause.
REQ-018 IDLE: key_rec -> RECORD with sram_addr=0; key_play -> PLAY with sram_addr=0 only if end_addr != 0, else ignored; key_pause ignored.
REQ-019 PLAY: key_pause -> PAUSE, address held; key_stop -> IDLE, sram_addr=0; key_rec -> RECORD, sram_addr=0; key_play ignored.
REQ-020 PAUSE: key_play -> PLAY, resuming at held address; key_stop and key_rec as in PLAY; key_pause ignored.
REQ-021 RECORD: key_stop -> IDLE, end_addr keeps last written address; key_play, key_pause, key_rec ignored.
REQ-022 sram_oe_n=0 in PLAY and PAUSE, 1 otherwise; sram_we_n=1 outside RECORD.
REQ-023 RECORD: adc_valid drives sram_we_n=0 for exactly the next cycle at current sram_addr; the cycle after, end_addr<=sram_addr and sram_addr increments by 1.
REQ-024 adc_valid arriving while sram_we_n=0 is ignored (no queuing).
REQ-025 RECORD write at sram_addr==ADDR_MAX: no increment; done pulses, state -> IDLE.
REQ-026 PLAY: internal registered daclrc copy detects rising edges; each edge increments a 4-bit frame counter.
REQ-027 When the frame counter reaches slow_eff-1 it clears and sram_addr advances by fast_eff in the same cycle.
REQ-028 Advance computed 19-bit wide; if sram_addr+fast_eff > end_addr, done pulses, state -> IDLE, sram_addr=0.
REQ-029 Frame counter clears on any state entry; PAUSE freezes it.
REQ-030 done never pulses on key_stop.

Reset
REQ-031 rst: state=IDLE, sram_addr=0, end_addr=0, frame counter=0, sram_we_n=1, sram_oe_n=1, play=0, rec=0, done=0.
REQ-032 rst mid-write forces sram_we_n=1 the next cycle; recorded length is discarded.
REQ-033 rst takes priority over all command inputs in the same cycle.

Configuration
REQ-034 Macro PLAY_CTRL_LOOP_EN defined: REQ-028 end condition wraps sram_addr to 0, stays in PLAY, still pulses done.
REQ-035 Macro undefined: behaviour exactly as REQ-028.

Verification
REQ-036 Reset, key_rec, 5 adc_valid pulses 4 cycles apart, key_stop -> five we_n lows at addr 0..4; IDLE; end_addr=4.
REQ-037 After REQ-036, key_play, fast=1, slow=1 -> sram_addr 0,1,2,3,4 on successive daclrc rises; next rise done=1, state=IDLE, addr=0.
REQ-038 end_addr=10, fast=3, slow=2 -> addr 0,3,6,9 each held 2 frames; next advance (12>10) -> done, IDLE.
REQ-039 PLAY at addr 6, key_pause, 3 daclrc rises, key_play -> addr stays 6 during PAUSE, resumes from 6 with counter cleared.
REQ-040 key_stop and key_play same cycle in PLAY -> IDLE, addr=0, done=0; with PLAY_CTRL_LOOP_EN, REQ-037 end wraps to 0 with done pulse, state stays PLAY.
